// File: rtl/mips_pkg.sv
// Shared MIPS-Lite definitions: datapath width, register-specifier width,
// HALT opcode and the hazard-controller FSM encoding.
package mips_pkg;

  localparam int DATA             = 32;
  localparam int REG_W_DEF        = 5;
  localparam int DRAIN_CYCLES_DEF = 3;   // EX, MEM, WB behind HALT

  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // next count: +1 when enabled and not yet saturated
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  // count register, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / halt sequencer for the 5-stage MIPS-Lite pipeline.
// Hazard outputs are combinational from the ID/EX stage fields; HALT freezes
// fetch, drains the remaining stages, then reports a sticky halted.
module pipeline_hazard_ctrl import mips_pkg::*; #(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32,
  parameter int REG_W        = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_halt,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             hazard_detected,
  output logic             halt_signal,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int            DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  hz_state_e      state_q;
  logic [DCW-1:0] drain_q;
  logic           halted_q;

  logic load_use, halt_now;
  logic hazard_d, halt_sig_d, flush_d, bubble_d;

  // r0 is hardwired zero, so a load to it never creates a dependency
  assign load_use = ex_valid & ex_is_load & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // taken branch squashes whatever sits in ID; a load-use stall defers HALT
  assign halt_now = (state_q == ST_RUN) & id_valid & id_is_halt &
                    ~load_use & ~ex_branch_taken;

  // per-state control outputs; once halting, fetch stays frozen and squashed
  always_comb begin
    hazard_d   = 1'b0;
    halt_sig_d = 1'b0;
    flush_d    = 1'b0;
    bubble_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        hazard_d   = load_use & ~ex_branch_taken;
        halt_sig_d = halt_now;
        flush_d    = ex_branch_taken | halt_now;
        bubble_d   = ex_branch_taken | (load_use & ~ex_branch_taken);
      end
      default: begin
        halt_sig_d = 1'b1;
        flush_d    = 1'b1;
        bubble_d   = 1'b1;
      end
    endcase
  end

  // halt sequencer: RUN -> DRAIN (count down) -> HALTED until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_now) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        ST_HALTED: halted_q <= 1'b1;
        default:   state_q  <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (hazard_d),
    .count_o (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (state_q != ST_HALTED),
    .count_o (cycle_count)
  );

  assign hazard_detected = hazard_d;
  assign halt_signal     = halt_sig_d;
  assign ifid_flush      = flush_d;
  assign idex_bubble     = bubble_d;
  assign halted          = halted_q;

endmodule
